// File: rtl/imem_boot_loader_if.sv
// ============================================================================
// imem_boot_loader_if : program-source and instruction-memory bundle for the boot loader.
// Revision 1.0
// ============================================================================
`default_nettype none

interface imem_boot_loader_if #(
  parameter int CNT_W = 9
);
  logic             start;
  logic [CNT_W-1:0] word_count;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic             imem_we;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_wdata;
  logic             cpu_reset;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    output start, word_count, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, error
  );

  modport slave (
    input  start, word_count, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, error
  );
endinterface

`default_nettype wire

// File: rtl/imem_boot_loader.sv
// ============================================================================
// imem_boot_loader : streams program words into IMEM, holds the CPU in reset until loaded.
// Optional trailing-checksum verification: BOOT_CHECKSUM_EN.  Revision 1.0
// ============================================================================
`default_nettype none

module imem_boot_loader #(
  parameter int DEPTH = 256,
  parameter int CNT_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  imem_boot_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_wc;
  logic             r_in_ready;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_cpu_reset;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]      r_sum;
`endif

  logic w_hs;
  logic w_last;

  assign w_hs   = bus.in_valid & r_in_ready;
  assign w_last = (r_idx == (r_wc - C_ONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_wc        <= '0;
      r_in_ready  <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.start) begin
            r_wc  <= bus.word_count;
            r_idx <= '0;
`ifdef BOOT_CHECKSUM_EN
            r_sum <= '0;
`endif
            if (bus.word_count == '0) begin
              r_state     <= S_DONE;
              r_in_ready  <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_error     <= 1'b0;
              r_cpu_reset <= 1'b0;
            end else if (bus.word_count > C_DEPTH) begin
              r_state     <= S_ERROR;
              r_in_ready  <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b0;
              r_error     <= 1'b1;
              r_cpu_reset <= 1'b1;
            end else begin
              r_state     <= S_LOAD;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b1;
              r_done      <= 1'b0;
              r_error     <= 1'b0;
              r_cpu_reset <= 1'b1;
            end
          end else if (r_state == S_DONE) begin
            // Entry from LOAD leaves done low for one cycle so the final write lands first.
            r_done      <= 1'b1;
            r_cpu_reset <= 1'b0;
          end
        end

        S_LOAD: begin
          if (w_hs) begin
            r_we    <= 1'b1;
            r_addr  <= 32'(r_idx) << 2;
            r_wdata <= bus.in_data;
            r_idx   <= r_idx + C_ONE;
`ifdef BOOT_CHECKSUM_EN
            r_sum   <= r_sum + bus.in_data;
`endif
            if (w_last) begin
`ifdef BOOT_CHECKSUM_EN
              r_state    <= S_CHECK;
`else
              r_state    <= S_DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
`endif
            end
          end
        end

`ifdef BOOT_CHECKSUM_EN
        S_CHECK: begin
          if (w_hs) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            if (bus.in_data == r_sum) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
            end else begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end
          end
        end
`endif

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_error     <= 1'b0;
          r_cpu_reset <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign bus.cpu_reset  = r_cpu_reset;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.error      = r_error;

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
// ============================================================================
// tb_imem_boot_loader : directed + randomized checks of imem_boot_loader against a write-list model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_imem_boot_loader;

  localparam int DEPTH = 256;
  localparam int CNT_W = 9;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  imem_boot_loader_if #(.CNT_W(CNT_W)) bus ();

  imem_boot_loader #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         wq[$];
  wr_t         mon_w;
  int          cyc   = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] g_words [DEPTH];
`ifdef BOOT_CHECKSUM_EN
  logic [31:0] g_chk_delta = '0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // Observed memory writes, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      mon_w.addr = bus.imem_addr;
      mon_w.data = bus.imem_wdata;
      mon_w.cyc  = cyc;
      wq.push_back(mon_w);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_hs(input string tag);
    int budget;
    budget = 16;
    while (bus.in_ready !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    check({tag, "_hs_timeout"}, 32'(budget > 0), 32'd1);
    tick();
  endtask

  // Model: a load of n in-range words must yield exactly n writes, word i at byte address 4*i.
  task automatic do_load(input string tag, input int n, input int fixed_gap,
                         input int rand_gap, input bit mid_start);
    bit exp_done;
    bit b2b;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0] sum;
    sum = '0;
`endif
    b2b = (fixed_gap == 0) && (rand_gap == 0);
    wq.delete();
    bus.start      = 1'b1;
    bus.word_count = CNT_W'(n);
    tick();
    bus.start = 1'b0;
    check({tag, "_start_busy"},      32'(bus.busy),      32'd1);
    check({tag, "_start_cpu_reset"}, 32'(bus.cpu_reset), 32'd1);
    check({tag, "_start_done"},      32'(bus.done),      32'd0);
    for (int i = 0; i < n; i++) begin
      int gap;
      if (i > 0) begin
        gap = fixed_gap + ((rand_gap > 0) ? int'($urandom_range(rand_gap, 0)) : 0);
        for (int g = 0; g < gap; g++) begin
          bus.in_valid = 1'b0;
          bus.in_data  = $urandom();
          tick();
          check({tag, "_stall_busy"}, 32'(bus.busy), 32'd1);
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = g_words[i];
`ifdef BOOT_CHECKSUM_EN
      sum = sum + g_words[i];
`endif
      if (mid_start && i == n / 2) begin
        bus.start      = 1'b1;
        bus.word_count = CNT_W'(1);
      end
      wait_hs(tag);
      bus.start = 1'b0;
    end
    bus.in_valid = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    check({tag, "_check_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = sum + g_chk_delta;
    wait_hs({tag, "_chk"});
    bus.in_valid = 1'b0;
    exp_done = (g_chk_delta == '0);
`else
    check({tag, "_last_we"},        32'(bus.imem_we),   32'd1);
    check({tag, "_last_done"},      32'(bus.done),      32'd0);
    check({tag, "_last_cpu_reset"}, 32'(bus.cpu_reset), 32'd1);
    check({tag, "_last_in_ready"},  32'(bus.in_ready),  32'd0);
    tick();
    exp_done = 1'b1;
`endif
    check({tag, "_end_done"},      32'(bus.done),      32'(exp_done));
    check({tag, "_end_error"},     32'(bus.error),     32'(!exp_done));
    check({tag, "_end_cpu_reset"}, 32'(bus.cpu_reset), 32'(!exp_done));
    check({tag, "_end_busy"},      32'(bus.busy),      32'd0);
    check({tag, "_end_in_ready"},  32'(bus.in_ready),  32'd0);
    check({tag, "_end_we"},        32'(bus.imem_we),   32'd0);
    tick();
    check({tag, "_nwr"}, 32'(wq.size()), 32'(n));
    for (int i = 0; i < n && i < int'(wq.size()); i++) begin
      check({tag, "_addr"}, wq[i].addr, 32'(i * 4));
      check({tag, "_data"}, wq[i].data, g_words[i]);
      if (b2b) check({tag, "_b2b_cycle"}, 32'(wq[i].cyc), 32'(wq[0].cyc + i));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start      = 1'b0;
    bus.word_count = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    reset          = 1'b1;
    tick();
    tick();
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_we",        32'(bus.imem_we),   32'd0);
    check("rst_addr",      bus.imem_addr,      32'd0);
    check("rst_wdata",     bus.imem_wdata,     32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_done",      32'(bus.done),      32'd0);
    check("rst_error",     32'(bus.error),     32'd0);
    check("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);

    reset = 1'b0;
    wq.delete();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    tick();
    tick();
    tick();
    check("idle_in_ready",  32'(bus.in_ready),  32'd0);
    check("idle_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("idle_nwr",       32'(wq.size()),     32'd0);
    bus.in_valid = 1'b0;

    g_words[0] = 32'h2008_0005;
    g_words[1] = 32'h2009_0007;
    g_words[2] = 32'h0109_5020;
    do_load("b2b3", 3, 0, 0, 1'b0);

    g_words[0] = $urandom();
    g_words[1] = $urandom();
    do_load("gap4", 2, 4, 0, 1'b0);

`ifdef BOOT_CHECKSUM_EN
    g_words[0]  = 32'h0000_0001;
    g_chk_delta = 32'h0000_0001;
    do_load("badchk", 1, 0, 0, 1'b0);
    g_chk_delta = '0;
    do_load("goodchk", 1, 0, 0, 1'b0);
`endif

    wq.delete();
    bus.start      = 1'b1;
    bus.word_count = CNT_W'(DEPTH + 1);
    tick();
    bus.start = 1'b0;
    check("ovf_error",     32'(bus.error),     32'd1);
    check("ovf_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("ovf_busy",      32'(bus.busy),      32'd0);
    check("ovf_in_ready",  32'(bus.in_ready),  32'd0);
    check("ovf_done",      32'(bus.done),      32'd0);
    tick();
    tick();
    check("ovf_nwr", 32'(wq.size()), 32'd0);

    for (int i = 0; i < 5; i++) g_words[i] = $urandom();
    do_load("from_err", 5, 0, 2, 1'b0);

    wq.delete();
    bus.start      = 1'b1;
    bus.word_count = '0;
    tick();
    bus.start = 1'b0;
    check("zero_done",      32'(bus.done),      32'd1);
    check("zero_cpu_reset", 32'(bus.cpu_reset), 32'd0);
    check("zero_error",     32'(bus.error),     32'd0);
    check("zero_in_ready",  32'(bus.in_ready),  32'd0);
    tick();
    tick();
    check("zero_nwr", 32'(wq.size()), 32'd0);

    for (int i = 0; i < 4; i++) g_words[i] = $urandom();
    wq.delete();
    bus.start      = 1'b1;
    bus.word_count = CNT_W'(4);
    tick();
    bus.start = 1'b0;
    check("rmid_cpu_reset_up", 32'(bus.cpu_reset), 32'd1);
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = g_words[i];
      wait_hs("rmid");
    end
    bus.in_data = g_words[2];
    reset       = 1'b1;
    tick();
    check("rmid_we",        32'(bus.imem_we),   32'd0);
    check("rmid_in_ready",  32'(bus.in_ready),  32'd0);
    check("rmid_busy",      32'(bus.busy),      32'd0);
    check("rmid_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("rmid_addr",      bus.imem_addr,      32'd0);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("rmid_nwr", 32'(wq.size()), 32'd2);
    for (int i = 0; i < 4; i++) g_words[i] = $urandom();
    do_load("after_rst", 4, 0, 0, 1'b0);

    for (int i = 0; i < 6; i++) g_words[i] = $urandom();
    do_load("midstart", 6, 0, 0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(12, 1));
      for (int i = 0; i < n; i++) g_words[i] = $urandom();
      do_load("rand", n, 0, 3, 1'b0);
    end

    for (int i = 0; i < DEPTH; i++) g_words[i] = $urandom();
    do_load("full", DEPTH, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
